// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        SETTLE,
        RUN,
        LOST
    } pll_state_t;

    localparam int unsigned DIAG_W = 8;

    // Width of the shared phase counter: enough to count to the largest limit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the reference-clocked PLL through reset, lock qualification and
// settle, and holds the system in reset until a qualified lock has persisted.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES       = 65536,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_FILTER         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_lock,
    output logic              pll_resetb,
    output logic              pll_bypass,
    output logic              sys_reset,
    output logic              locked,
    output logic [DIAG_W-1:0] retry_count,
    output logic [DIAG_W-1:0] loss_count
);

    localparam int unsigned CNT_W  = cnt_width(SETTLE_CYCLES, LOCK_TIMEOUT_CYCLES, PLL_RESET_CYCLES);
    localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_MAX     = FILT_W'(LOCK_FILTER);

    pll_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [FILT_W-1:0] filt;
    logic              lock_s;
    logic              lock_ok;
    logic              retry_inc;
    logic              loss_inc;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign lock_ok = (filt == FILT_MAX);

    // Lock qualification: any low sample restarts the run of high samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= '0;
        end else if (!lock_s) begin
            filt <= '0;
        end else if (!lock_ok) begin
            filt <= filt + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HOLD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state)
            HOLD: begin
                if (cnt == HOLD_LAST) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_n = SETTLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n   = HOLD;
                    retry_inc = 1'b1;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                end else if (cnt == SETTLE_LAST) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                // Loss is acted on from the raw synchronised level, unfiltered.
                if (!lock_s) begin
                    state_n  = LOST;
                    loss_inc = 1'b1;
                end
            end
            LOST: begin
                state_n = HOLD;
            end
            default: begin
                state_n = HOLD;
            end
        endcase
    end

    // Shared phase counter, restarted on every state entry; idle in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else if (state != RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Outputs decoded from the next state so they move with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pll_resetb  <= 1'b0;
            pll_bypass  <= 1'b0;
            sys_reset   <= 1'b1;
            locked      <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            pll_resetb <= (state_n != HOLD);
            pll_bypass <= 1'b0;
            sys_reset  <= (state_n != RUN);
            locked     <= (state_n == RUN);
            if (retry_inc && (retry_count != '1)) begin
                retry_count <= retry_count + DIAG_W'(1);
            end
            if (loss_inc && (loss_count != '1)) begin
                loss_count <= loss_count + DIAG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: expected output-change events are
// queued by the stimulus and checked by an independent monitor.
module tb_pll_lock_supervisor;

    localparam int unsigned SETTLE = 100;
    localparam int unsigned TMO    = 1000;
    localparam int unsigned PRST   = 4;
    localparam int unsigned FILT   = 3;

    typedef struct packed {
        int unsigned edge_n;
        logic [19:0] obs;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_reset;
    logic       locked;
    logic [7:0] retry_count;
    logic [7:0] loss_count;

    int unsigned pe = 0;
    int          vectors = 0;
    int          miscompares = 0;
    ev_t         expq[$];

    logic [19:0] prev_obs;
    logic [19:0] cur_obs;
    ev_t         got_e;
    ev_t         exp_e;
    bit          first = 1'b1;

    pll_lock_supervisor #(
        .SETTLE_CYCLES       (SETTLE),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .PLL_RESET_CYCLES    (PRST),
        .LOCK_FILTER         (FILT)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .pll_lock    (pll_lock),
        .pll_resetb  (pll_resetb),
        .pll_bypass  (pll_bypass),
        .sys_reset   (sys_reset),
        .locked      (locked),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pe <= pe + 1;

    // Monitor: every observed output change must match the head of the queue.
    always @(negedge clk) begin
        cur_obs = {pll_bypass, pll_resetb, sys_reset, locked, retry_count, loss_count};
        if (first || (cur_obs != prev_obs)) begin
            first        = 1'b0;
            prev_obs     = cur_obs;
            got_e.edge_n = pe;
            got_e.obs    = cur_obs;
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change edge=%0d obs=%h", pe, cur_obs);
            end else begin
                exp_e = expq.pop_front();
                if (exp_e != got_e) begin
                    miscompares++;
                    $display("FAIL output_event got edge=%0d obs=%h, expected edge=%0d obs=%h",
                             got_e.edge_n, got_e.obs, exp_e.edge_n, exp_e.obs);
                end
            end
        end
    end

    task automatic push(input int unsigned e, input logic rb, input logic sr,
                        input logic lk, input int unsigned rt, input int unsigned ls);
        ev_t ev;
        ev.edge_n = e;
        ev.obs    = {1'b0, rb, sr, lk, 8'(rt), 8'(ls)};
        expq.push_back(ev);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int unsigned e);
        while (pe < e) tick(1);
    endtask

    // Asserts reset between edges; returns the edge count at release.
    task automatic do_reset(output int unsigned r);
        push(pe, 1'b0, 1'b1, 1'b0, 0, 0);
        rst      = 1'b1;
        pll_lock = 1'b0;
        tick(3);
        rst = 1'b0;
        r   = pe;
    endtask

    // Raise lock 10 cycles after PLL_RESETB rises and run through to RUN.
    task automatic bringup(input int unsigned r);
        int unsigned p;
        push(r + PRST, 1'b1, 1'b1, 1'b0, 0, 0);
        wait_to(r + PRST + 10);
        p        = pe;
        pll_lock = 1'b1;
        push(p + 2 + FILT + 1 + SETTLE, 1'b1, 1'b0, 1'b1, 0, 0);
        wait_to(p + 2 + FILT + 1 + SETTLE);
    endtask

    // One-cycle lock drop from RUN; optionally stop at SETTLE cnt=50.
    task automatic loss_cycle(input int unsigned ls, input bit to_run);
        int unsigned q;
        q = pe;
        push(q + 3, 1'b1, 1'b1, 1'b0, 0, ls);
        push(q + 4, 1'b0, 1'b1, 1'b0, 0, ls);
        push(q + 4 + PRST, 1'b1, 1'b1, 1'b0, 0, ls);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        if (to_run) begin
            push(q + 5 + PRST + SETTLE, 1'b1, 1'b0, 1'b1, 0, ls);
            wait_to(q + 5 + PRST + SETTLE);
        end else begin
            wait_to(q + 5 + PRST + 50);
        end
    endtask

    initial begin
        int unsigned r;
        int unsigned c;
        int unsigned d;
        int unsigned k;
        int unsigned ls;

        rst      = 1'b0;
        pll_lock = 1'b0;
        #0 rst = 1'b1;
        push(1, 1'b0, 1'b1, 1'b0, 0, 0);
        tick(3);
        rst = 1'b0;
        r   = pe;

        // Normal bring-up, then one loss in RUN with full re-lock.
        bringup(r);
        loss_cycle(1, 1'b1);

        // Loss-count saturation.
        for (int i = 0; i < 300; i++) begin
            ls = (2 + i > 255) ? 255 : 2 + i;
            loss_cycle(ls, 1'b1);
        end

        // Reset at SETTLE cnt=50, then a normal bring-up again.
        loss_cycle(255, 1'b0);
        do_reset(r);
        bringup(r);
        tick(2);

        // Lock never asserts: periodic re-reset with retry counting.
        do_reset(r);
        for (int i = 0; i < 3; i++) begin
            push(r + PRST + i * (PRST + TMO), 1'b1, 1'b1, 1'b0, i, 0);
            push(r + (i + 1) * (PRST + TMO), 1'b0, 1'b1, 1'b0, i + 1, 0);
        end
        push(r + PRST + 3 * (PRST + TMO), 1'b1, 1'b1, 1'b0, 3, 0);
        wait_to(r + 3020);

        // Chattering lock never qualifies; then a drop during SETTLE.
        do_reset(r);
        push(r + PRST, 1'b1, 1'b1, 1'b0, 0, 0);
        push(r + PRST + TMO, 1'b0, 1'b1, 1'b0, 1, 0);
        push(r + 2 * PRST + TMO, 1'b1, 1'b1, 1'b0, 1, 0);
        k = 0;
        while (pe < r + 1010) begin
            pll_lock = (k % 3) != 2;
            k++;
            tick(1);
        end
        pll_lock = 1'b0;
        wait_to(r + 1015);
        c        = pe;
        pll_lock = 1'b1;
        d        = c + 2 + FILT + 1 + 50;
        wait_to(d);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        push(d + 3 + FILT + 1 + SETTLE, 1'b1, 1'b0, 1'b1, 1, 0);
        wait_to(d + 3 + FILT + 1 + SETTLE + 3);

        tick(2);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events remaining=%0d required=0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
